m3ds_ahb_slave_mux: RTL and testbench

- Data-phase return path for the M3 DesignStart peripheral AHB subsystem. It is the counterpart of the address-phase HSEL decoder.
- Registers which slave owns the data phase and multiplexes HRDATA/HREADYOUT/HRESP from GPIO0..3 and SysCtrl back to the bus master.
- Contains the built-in default slave, with a two-cycle ERROR FSM.
- Protection-blocked accesses, where HSEL_i is high but no slave select is asserted, are routed to the default slave and fault.

---
 rtl/m3ds_ahb_slave_mux.sv | 224 ++++++++++++++++++++++
 tb/tb_m3ds_ahb_slave_mux.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m3ds_ahb_slave_mux.sv
// AHB data-phase return path for the M3 DesignStart peripheral subsystem.
// Tracks the data-phase owner, muxes slave responses and hosts the default (ERROR) slave.
module m3ds_ahb_slave_mux #(
    parameter int unsigned CNT_WIDTH = 8,
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic                 HCLK_i,
    input  logic                 HRESET_i,
    input  logic                 HSEL_i,
    input  logic [1:0]           HTRANS_i,
    input  logic                 HREADY_i,
    input  logic                 HSEL0_i,
    input  logic                 HSEL2_i,
    input  logic                 HSEL3_i,
    input  logic                 HSEL4_i,
    input  logic                 HSEL5_i,
    input  logic                 HSEL6_i,
    input  logic [31:0]          HRDATA2_i,
    input  logic [31:0]          HRDATA3_i,
    input  logic [31:0]          HRDATA4_i,
    input  logic [31:0]          HRDATA5_i,
    input  logic [31:0]          HRDATA6_i,
    input  logic                 HREADYOUT2_i,
    input  logic                 HREADYOUT3_i,
    input  logic                 HREADYOUT4_i,
    input  logic                 HREADYOUT5_i,
    input  logic                 HREADYOUT6_i,
    input  logic                 HRESP2_i,
    input  logic                 HRESP3_i,
    input  logic                 HRESP4_i,
    input  logic                 HRESP5_i,
    input  logic                 HRESP6_i,
    input  logic                 err_clr_i,
    output logic [31:0]          HRDATA_o,
    output logic                 HREADYOUT_o,
    output logic                 HRESP_o,
    output logic [CNT_WIDTH-1:0] err_count_o
);

    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_DEF     = 3'd1,
        SEL_GPIO0   = 3'd2,
        SEL_GPIO1   = 3'd3,
        SEL_GPIO2   = 3'd4,
        SEL_GPIO3   = 3'd5,
        SEL_SYSCTRL = 3'd6
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } st_e;

    // Lowest-index slave wins; an HSEL_i hit with no slave select is a protection fault.
    function automatic sel_e decode_sel(input logic hsel, input logic hsel0,
                                        input logic [4:0] hsel_slv);
        sel_e r;
        r = SEL_NONE;
        if (hsel_slv[0]) begin
            r = SEL_GPIO0;
        end else if (hsel_slv[1]) begin
            r = SEL_GPIO1;
        end else if (hsel_slv[2]) begin
            r = SEL_GPIO2;
        end else if (hsel_slv[3]) begin
            r = SEL_GPIO3;
        end else if (hsel_slv[4]) begin
            r = SEL_SYSCTRL;
        end else if (hsel0) begin
            r = SEL_DEF;
        end else if (hsel) begin
            r = SEL_DEF;
        end else begin
            r = SEL_NONE;
        end
        return r;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == {CNT_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_WIDTH'(1);
        end
        return r;
    endfunction

    sel_e                 sel_q, sel_d;
    st_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    sel_e                 addr_sel_s;
    logic                 cap_def_s;
    logic                 unused_s;

    // HTRANS_i[0] only separates NONSEQ/SEQ or IDLE/BUSY, which behave alike here.
    assign unused_s = HTRANS_i[0];

    // Address-phase decode and detection of an active transfer captured by the default slave.
    always_comb begin
        addr_sel_s = decode_sel(HSEL_i, HSEL0_i,
                                {HSEL6_i, HSEL5_i, HSEL4_i, HSEL3_i, HSEL2_i});
        cap_def_s  = HREADY_i & (addr_sel_s == SEL_DEF) & HTRANS_i[1];
    end

    // Data-phase owner only advances when the bus accepts an address phase.
    always_comb begin
        sel_d = sel_q;
        if (HREADY_i) begin
            sel_d = addr_sel_s;
        end else begin
            sel_d = sel_q;
        end
    end

    // Default-slave ERROR sequencer next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cap_def_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: begin
                if (cap_def_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error counter: clear beats a same-cycle ERR1 entry.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr_i) begin
            err_count_d = {CNT_WIDTH{1'b0}};
        end else if (state_d == ST_ERR1) begin
            err_count_d = sat_inc(err_count_q);
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State registers.
    always_ff @(posedge HCLK_i or posedge HRESET_i) begin
        if (HRESET_i) begin
            sel_q       <= SEL_NONE;
            state_q     <= ST_IDLE;
            err_count_q <= {CNT_WIDTH{1'b0}};
        end else begin
            sel_q       <= sel_d;
            state_q     <= state_d;
            err_count_q <= err_count_d;
        end
    end

    // Response mux driven from the registered owner so slaves pass through without added waits.
    always_comb begin
        HRDATA_o    = 32'h0000_0000;
        HREADYOUT_o = 1'b1;
        HRESP_o     = 1'b0;
        case (sel_q)
            SEL_GPIO0: begin
                HRDATA_o    = HRDATA2_i;
                HREADYOUT_o = HREADYOUT2_i;
                HRESP_o     = HRESP2_i;
            end
            SEL_GPIO1: begin
                HRDATA_o    = HRDATA3_i;
                HREADYOUT_o = HREADYOUT3_i;
                HRESP_o     = HRESP3_i;
            end
            SEL_GPIO2: begin
                HRDATA_o    = HRDATA4_i;
                HREADYOUT_o = HREADYOUT4_i;
                HRESP_o     = HRESP4_i;
            end
            SEL_GPIO3: begin
                HRDATA_o    = HRDATA5_i;
                HREADYOUT_o = HREADYOUT5_i;
                HRESP_o     = HRESP5_i;
            end
            SEL_SYSCTRL: begin
                HRDATA_o    = HRDATA6_i;
                HREADYOUT_o = HREADYOUT6_i;
                HRESP_o     = HRESP6_i;
            end
            SEL_DEF: begin
                HRDATA_o = ERR_RDATA;
                case (state_q)
                    ST_ERR1: begin
                        HREADYOUT_o = 1'b0;
                        HRESP_o     = 1'b1;
                    end
                    ST_ERR2: begin
                        HREADYOUT_o = 1'b1;
                        HRESP_o     = 1'b1;
                    end
                    default: begin
                        HREADYOUT_o = 1'b1;
                        HRESP_o     = 1'b0;
                    end
                endcase
            end
            default: begin
                HRDATA_o    = 32'h0000_0000;
                HREADYOUT_o = 1'b1;
                HRESP_o     = 1'b0;
            end
        endcase
    end

    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_m3ds_ahb_slave_mux.sv
// Directed bench for m3ds_ahb_slave_mux: slave pass-through, wait states, default slave, counter, reset.
module tb_m3ds_ahb_slave_mux;

    logic        clk;
    logic        rst;
    logic        hsel, hsel0, hsel2, hsel3, hsel4, hsel5, hsel6;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] rd2, rd3, rd4, rd5, rd6;
    logic        ro2, ro3, ro4, ro5, ro6;
    logic        rs2, rs3, rs4, rs5, rs6;
    logic        err_clr;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic [1:0]  err_count;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    m3ds_ahb_slave_mux #(.CNT_WIDTH(2), .ERR_RDATA(ERRD)) dut (
        .HCLK_i(clk), .HRESET_i(rst), .HSEL_i(hsel), .HTRANS_i(htrans), .HREADY_i(hready),
        .HSEL0_i(hsel0), .HSEL2_i(hsel2), .HSEL3_i(hsel3), .HSEL4_i(hsel4),
        .HSEL5_i(hsel5), .HSEL6_i(hsel6),
        .HRDATA2_i(rd2), .HRDATA3_i(rd3), .HRDATA4_i(rd4), .HRDATA5_i(rd5), .HRDATA6_i(rd6),
        .HREADYOUT2_i(ro2), .HREADYOUT3_i(ro3), .HREADYOUT4_i(ro4),
        .HREADYOUT5_i(ro5), .HREADYOUT6_i(ro6),
        .HRESP2_i(rs2), .HRESP3_i(rs3), .HRESP4_i(rs4), .HRESP5_i(rs5), .HRESP6_i(rs6),
        .err_clr_i(err_clr),
        .HRDATA_o(hrdata), .HREADYOUT_o(hreadyout), .HRESP_o(hresp), .err_count_o(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic exp_rdy, input logic exp_resp);
        chk({tag, "_rdy"}, {31'd0, hreadyout}, {31'd0, exp_rdy});
        chk({tag, "_resp"}, {31'd0, hresp}, {31'd0, exp_resp});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic s, input logic s0, input logic [4:0] sx, input logic [1:0] tr);
        hsel   = s;
        hsel0  = s0;
        hsel2  = sx[0];
        hsel3  = sx[1];
        hsel4  = sx[2];
        hsel5  = sx[3];
        hsel6  = sx[4];
        htrans = tr;
    endtask

    task automatic idle_addr;
        set_addr(1'b0, 1'b0, 5'b00000, 2'b00);
    endtask

    task automatic err_seq;
        set_addr(1'b1, 1'b1, 5'b00000, 2'b10);
        tick;
        idle_addr;
        hready = 1'b0;
        tick;
        hready = 1'b1;
        tick;
        #1;
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; hready = 1'b1;
        idle_addr;
        rd2 = 32'h2222_0002; rd3 = 32'h3333_0003; rd4 = 32'h4444_0004;
        rd5 = 32'h5555_0005; rd6 = 32'h6666_0006;
        ro2 = 1'b1; ro3 = 1'b1; ro4 = 1'b1; ro5 = 1'b1; ro6 = 1'b1;
        rs2 = 1'b0; rs3 = 1'b0; rs4 = 1'b0; rs5 = 1'b0; rs6 = 1'b0;
        #1;
        chk("rst_rdata", hrdata, 32'h0000_0000);
        chk_bus("rst", 1'b1, 1'b0);
        chk("rst_cnt", {30'd0, err_count}, 32'd0);
        tick;
        tick;
        rst = 1'b0;

        // GPIO1 zero-wait read and response pass-through
        set_addr(1'b1, 1'b0, 5'b00010, 2'b10);
        tick;
        idle_addr;
        rd3 = 32'hA5A5_0011;
        #1;
        chk("gpio1_rdata", hrdata, 32'hA5A5_0011);
        chk_bus("gpio1", 1'b1, 1'b0);
        rs3 = 1'b1;
        #1;
        chk("gpio1_resp_pass", {31'd0, hresp}, 32'd1);
        rs3 = 1'b0;

        // Lowest index wins when two slave selects collide
        set_addr(1'b1, 1'b0, 5'b00101, 2'b10);
        tick;
        idle_addr;
        #1;
        chk("prio_rdata", hrdata, 32'h2222_0002);
        tick;
        #1;
        chk("none_rdata", hrdata, 32'h0000_0000);
        chk_bus("none", 1'b1, 1'b0);

        // SysCtrl with three wait states; pending GPIO0 address must not be captured early
        set_addr(1'b1, 1'b0, 5'b10000, 2'b10);
        tick;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick;
            ro6 = 1'b0;
            hready = 1'b0;
            set_addr(1'b1, 1'b0, 5'b00001, 2'b10);
            #1;
            chk("sys_wait_rdy", {31'd0, hreadyout}, 32'd0);
            chk("sys_wait_rdata", hrdata, 32'h6666_0006);
        end
        tick;
        ro6 = 1'b1;
        hready = 1'b1;
        #1;
        chk("sys_done_rdy", {31'd0, hreadyout}, 32'd1);
        chk("sys_done_rdata", hrdata, 32'h6666_0006);
        tick;
        idle_addr;
        #1;
        chk("gpio0_after_wait", hrdata, 32'h2222_0002);

        // Default-slave NONSEQ: ERR1, ERR2, IDLE
        chk("def_cnt_before", {30'd0, err_count}, 32'd0);
        set_addr(1'b1, 1'b1, 5'b00000, 2'b10);
        tick;
        idle_addr;
        hready = 1'b0;
        #1;
        chk_bus("def_err1", 1'b0, 1'b1);
        chk("def_rdata", hrdata, ERRD);
        chk("def_cnt", {30'd0, err_count}, 32'd1);
        tick;
        hready = 1'b1;
        #1;
        chk_bus("def_err2", 1'b1, 1'b1);
        tick;
        #1;
        chk_bus("def_idle", 1'b1, 1'b0);

        // IDLE transfer to the default slave completes OKAY without counting
        set_addr(1'b1, 1'b1, 5'b00000, 2'b00);
        tick;
        idle_addr;
        #1;
        chk("def_idle_tr_rdata", hrdata, ERRD);
        chk_bus("def_idle_tr", 1'b1, 1'b0);
        chk("def_idle_tr_cnt", {30'd0, err_count}, 32'd1);

        // Protection fault: HSEL_i with no slave select, SEQ
        set_addr(1'b1, 1'b0, 5'b00000, 2'b11);
        tick;
        idle_addr;
        hready = 1'b0;
        #1;
        chk_bus("prot_err1", 1'b0, 1'b1);
        chk("prot_cnt", {30'd0, err_count}, 32'd2);
        tick;
        hready = 1'b1;
        #1;
        chk_bus("prot_err2", 1'b1, 1'b1);
        tick;
        #1;
        chk_bus("prot_idle", 1'b1, 1'b0);

        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        #1;
        chk("clr_cnt", {30'd0, err_count}, 32'd0);

        // Back-to-back default-slave transfers
        set_addr(1'b1, 1'b1, 5'b00000, 2'b10);
        tick;
        hready = 1'b0;
        #1;
        chk_bus("b2b_err1a", 1'b0, 1'b1);
        chk("b2b_cnt1", {30'd0, err_count}, 32'd1);
        tick;
        hready = 1'b1;
        #1;
        chk_bus("b2b_err2a", 1'b1, 1'b1);
        tick;
        idle_addr;
        hready = 1'b0;
        #1;
        chk_bus("b2b_err1b", 1'b0, 1'b1);
        chk("b2b_cnt2", {30'd0, err_count}, 32'd2);
        tick;
        hready = 1'b1;
        #1;
        chk_bus("b2b_err2b", 1'b1, 1'b1);
        tick;
        #1;
        chk_bus("b2b_idle", 1'b1, 1'b0);
        chk("b2b_cnt_end", {30'd0, err_count}, 32'd2);

        // Saturation at 3 for a 2-bit counter
        err_seq;
        chk("sat_cnt3", {30'd0, err_count}, 32'd3);
        err_seq;
        chk("sat_cnt4", {30'd0, err_count}, 32'd3);

        // Real slave captured during ERR2
        set_addr(1'b1, 1'b1, 5'b00000, 2'b10);
        tick;
        idle_addr;
        hready = 1'b0;
        tick;
        hready = 1'b1;
        set_addr(1'b1, 1'b0, 5'b00100, 2'b10);
        tick;
        idle_addr;
        #1;
        chk("err2_to_slv_rdata", hrdata, 32'h4444_0004);
        chk_bus("err2_to_slv", 1'b1, 1'b0);
        set_addr(1'b1, 1'b1, 5'b00000, 2'b00);
        tick;
        idle_addr;
        #1;
        chk_bus("fsm_back_idle", 1'b1, 1'b0);

        // Clear wins over a same-cycle ERR1 entry
        set_addr(1'b1, 1'b1, 5'b00000, 2'b10);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        idle_addr;
        hready = 1'b0;
        #1;
        chk("clr_vs_inc_cnt", {30'd0, err_count}, 32'd0);
        chk_bus("clr_vs_inc", 1'b0, 1'b1);
        tick;
        hready = 1'b1;
        tick;

        // Reset asserted during ERR1
        set_addr(1'b1, 1'b0, 5'b00000, 2'b10);
        tick;
        idle_addr;
        hready = 1'b0;
        #1;
        chk("pre_rst_cnt", {30'd0, err_count}, 32'd1);
        chk_bus("pre_rst", 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_bus("mid_rst", 1'b1, 1'b0);
        chk("mid_rst_cnt", {30'd0, err_count}, 32'd0);
        chk("mid_rst_rdata", hrdata, 32'h0000_0000);
        hready = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        #1;
        chk_bus("post_rst", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
